// File: rtl/ifetch.sv
// ifetch: instruction fetch/prefetch unit.
// Reads 32-bit words from instruction memory (one request in flight at most),
// splits each word into two 16-bit halfwords, buffers them in a small queue
// and hands them to decode one per accepted cycle. Redirects flush the queue
// and restart fetch; a request already on the bus is absorbed via 'discard'.
module ifetch #(
    parameter int            RV       = 32,
    parameter int            QDEPTH   = 4,
    parameter logic [RV-1:0] RESET_PC = {RV{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic [RV-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    input  logic          dec_ready,
    output logic [15:0]   ins,
    output logic [RV-1:0] ins_pc,
    output logic          rdone,
    input  logic          redir,
    input  logic [RV-1:0] redir_pc,
    output logic          fetch_fault
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_TWO   = {{(CW-2){1'b0}}, 2'b10};
    localparam logic [CW-1:0]   CNT_QD    = CW'(QDEPTH);
    localparam logic [PW-1:0]   PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0]   PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [RV-1:0]   PC_STEP2  = {{(RV-2){1'b0}}, 2'b10};
    localparam logic [RV-1:2]   WA_STEP1  = {{(RV-3){1'b0}}, 1'b1};

    // Fetch word address (byte address bits [1:0] are implied zero)
    logic [RV-1:2] fwa_r,     fwa_nx_s;
    logic [RV-1:0] ins_pc_r,  ins_pc_nx_s;
    logic [RV-1:0] addr_r,    addr_nx_s;
    logic [PW-1:0] rd_ptr_r,  rd_ptr_nx_s;
    logic [PW-1:0] wr_ptr_r,  wr_ptr_nx_s;
    logic [PW-1:0] wr_ptr_p1_s;
    logic [CW-1:0] cnt_r,     cnt_nx_s;
    logic [CW-1:0] push_n_s;
    logic [CW-1:0] pop_n_s;
    logic          req_r,     req_nx_s;
    logic          discard_r, discard_nx_s;
    logic          skip_lo_r, skip_lo_nx_s;
    logic          fault_r,   fault_nx_s;
    logic          ack_s;
    logic          rdone_s;
    logic          push_lo_s;
    logic          push_hi_s;
    logic [15:0]   q_r [QDEPTH];

    // An ack only counts when it completes our own outstanding request
    assign ack_s       = mem_ack & req_r;
    // Hand a halfword to decode when one is buffered, decode accepts, and no redirect
    assign rdone_s     = (cnt_r != CNT_ZERO) & dec_ready & ~redir;
    assign wr_ptr_p1_s = wr_ptr_r + PTR_ONE;

    // Next-state logic: redirect first, then ack absorption/push, pop, and issue
    always_comb begin
        fwa_nx_s     = fwa_r;
        ins_pc_nx_s  = ins_pc_r;
        addr_nx_s    = addr_r;
        rd_ptr_nx_s  = rd_ptr_r;
        wr_ptr_nx_s  = wr_ptr_r;
        cnt_nx_s     = cnt_r;
        req_nx_s     = req_r;
        discard_nx_s = discard_r;
        skip_lo_nx_s = skip_lo_r;
        fault_nx_s   = fault_r;
        push_lo_s    = 1'b0;
        push_hi_s    = 1'b0;
        push_n_s     = CNT_ZERO;
        pop_n_s      = CNT_ZERO;

        if (redir) begin
            // Flush and restart; a request still on the bus must be absorbed later
            fwa_nx_s     = redir_pc[RV-1:2];
            ins_pc_nx_s  = redir_pc;
            skip_lo_nx_s = redir_pc[1];
            fault_nx_s   = redir_pc[0];
            rd_ptr_nx_s  = PTR_ZERO;
            wr_ptr_nx_s  = PTR_ZERO;
            cnt_nx_s     = CNT_ZERO;
            discard_nx_s = req_r & ~mem_ack;
        end else begin
            if (ack_s) begin
                if (discard_r) begin
                    // Stale word from before a redirect: drop it
                    discard_nx_s = 1'b0;
                end else begin
                    push_lo_s    = ~skip_lo_r;
                    push_hi_s    = 1'b1;
                    skip_lo_nx_s = 1'b0;
                    fwa_nx_s     = fwa_r + WA_STEP1;
                end
            end else begin
                discard_nx_s = discard_r;
            end

            if (push_lo_s) begin
                push_n_s = CNT_TWO;
            end else if (push_hi_s) begin
                push_n_s = CNT_ONE;
            end else begin
                push_n_s = CNT_ZERO;
            end

            if (rdone_s) begin
                pop_n_s     = CNT_ONE;
                rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
                ins_pc_nx_s = ins_pc_r + PC_STEP2;
            end else begin
                pop_n_s     = CNT_ZERO;
            end

            cnt_nx_s    = cnt_r + push_n_s - pop_n_s;
            wr_ptr_nx_s = wr_ptr_r + push_n_s[PW-1:0];
        end

        // Request stays up until acked; a new one issues only with room for a full word
        if (req_r) begin
            req_nx_s = ~ack_s;
        end else if (~fault_nx_s && ((cnt_nx_s + CNT_TWO) <= CNT_QD)) begin
            req_nx_s  = 1'b1;
            addr_nx_s = {fwa_nx_s, 2'b00};
        end else begin
            req_nx_s = 1'b0;
        end
    end

    // Control and pointer state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwa_r     <= RESET_PC[RV-1:2];
            ins_pc_r  <= RESET_PC;
            addr_r    <= {RESET_PC[RV-1:2], 2'b00};
            rd_ptr_r  <= PTR_ZERO;
            wr_ptr_r  <= PTR_ZERO;
            cnt_r     <= CNT_ZERO;
            req_r     <= 1'b0;
            discard_r <= 1'b0;
            skip_lo_r <= RESET_PC[1];
            fault_r   <= 1'b0;
        end else begin
            fwa_r     <= fwa_nx_s;
            ins_pc_r  <= ins_pc_nx_s;
            addr_r    <= addr_nx_s;
            rd_ptr_r  <= rd_ptr_nx_s;
            wr_ptr_r  <= wr_ptr_nx_s;
            cnt_r     <= cnt_nx_s;
            req_r     <= req_nx_s;
            discard_r <= discard_nx_s;
            skip_lo_r <= skip_lo_nx_s;
            fault_r   <= fault_nx_s;
        end
    end

    // Halfword queue storage: low half first so program order is preserved
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_r[i] <= 16'h0000;
            end
        end else if (push_lo_s) begin
            q_r[wr_ptr_r]    <= mem_rdata[15:0];
            q_r[wr_ptr_p1_s] <= mem_rdata[31:16];
        end else if (push_hi_s) begin
            q_r[wr_ptr_r]    <= mem_rdata[31:16];
        end else begin
            q_r[wr_ptr_r]    <= q_r[wr_ptr_r];
        end
    end

    assign mem_req     = req_r;
    assign mem_addr    = addr_r;
    assign ins         = q_r[rd_ptr_r];
    assign ins_pc      = ins_pc_r;
    assign rdone       = rdone_s;
    assign fetch_fault = fault_r;

endmodule
